// File: rtl/traffic_generator.sv
// traffic_generator
//   Packet source that feeds enqueues into a PIFO. Each cycle it makes a
//   pseudo-random injection decision against a programmable rate. An injected
//   packet gets a sequential pointer and a masked pseudo-random priority, and
//   it is held stable until the PIFO accepts it. An optional packet limit
//   ends the run, and o__done is raised when the limit is reached.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   i__inj_rate         inject when the injection LFSR < rate (0 = never)
//   i__inj_seed         injection LFSR seed, loaded at reset (0 -> 1)
//   i__prio_seed        priority LFSR seed, loaded at reset (0 -> 1)
//   i__prio_mask        AND-mask applied to generated priorities
//   i__num_pkts         packet limit, 0 = unlimited
//   i__inject_phase     injection permitted this cycle
//   i__pifo_ready       PIFO can accept an enqueue this cycle
//   o__enqueue          enqueue strobe (pending && ready)
//   o__packet_pointer   pointer of the pending packet
//   o__packet_priority  priority of the pending packet
//   o__num_pkts_sent    accepted enqueues, saturating
//   o__done             packet limit reached
module traffic_generator #(
  parameter int PTR_W  = 16,
  parameter int PRIO_W = 16,
  parameter int RATE_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RATE_W-1:0] i__inj_rate,
  input  logic [RATE_W-1:0] i__inj_seed,
  input  logic [PRIO_W-1:0] i__prio_seed,
  input  logic [PRIO_W-1:0] i__prio_mask,
  input  logic [CNT_W-1:0]  i__num_pkts,
  input  logic              i__inject_phase,
  input  logic              i__pifo_ready,
  output logic              o__enqueue,
  output logic [PTR_W-1:0]  o__packet_pointer,
  output logic [PRIO_W-1:0] o__packet_priority,
  output logic [CNT_W-1:0]  o__num_pkts_sent,
  output logic              o__done
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Maximal-length tap masks (bit k-1 set for tap k). The register shifts
  // towards the MSB, so the top bit is always a tap and the map stays
  // invertible; unlisted widths fall back to the top two bits.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       lfsr_taps = 32'h0000_0003;
      3:       lfsr_taps = 32'h0000_0006;
      4:       lfsr_taps = 32'h0000_000C;
      5:       lfsr_taps = 32'h0000_0014;
      6:       lfsr_taps = 32'h0000_0030;
      7:       lfsr_taps = 32'h0000_0060;
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0829;
      13:      lfsr_taps = 32'h0000_100D;
      14:      lfsr_taps = 32'h0000_2015;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_D008;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = (32'h0000_0001 << (w - 1)) | (32'h0000_0001 << (w - 2));
    endcase
  endfunction

  localparam logic [RATE_W-1:0] INJ_TAPS  = RATE_W'(lfsr_taps(RATE_W));
  localparam logic [PRIO_W-1:0] PRIO_TAPS = PRIO_W'(lfsr_taps(PRIO_W));

  function automatic logic [RATE_W-1:0] inj_step(input logic [RATE_W-1:0] s);
    inj_step = {s[RATE_W-2:0], ^(s & INJ_TAPS)};
  endfunction

  function automatic logic [PRIO_W-1:0] prio_step(input logic [PRIO_W-1:0] s);
    prio_step = {s[PRIO_W-2:0], ^(s & PRIO_TAPS)};
  endfunction

  logic [1:0]        state_r;
  logic [PTR_W-1:0]  pointer_r;
  logic [PRIO_W-1:0] priority_r;
  logic [PTR_W-1:0]  next_ptr_r;
  logic [CNT_W-1:0]  sent_r;
  logic [RATE_W-1:0] inj_lfsr_r;
  logic [PRIO_W-1:0] prio_lfsr_r;

  logic              accept_s;
  logic [CNT_W-1:0]  sent_next_s;
  logic [PTR_W-1:0]  next_ptr_next_s;
  logic              limit_hit_s;
  logic              cand_s;
  logic [1:0]        state_next_s;
  logic              latch_s;
  logic              inj_adv_s;
  logic [RATE_W-1:0] inj_seed_s;
  logic [PRIO_W-1:0] prio_seed_s;

  // Seeds of zero would lock the LFSRs, so they are replaced by one.
  assign inj_seed_s  = (i__inj_seed == '0)  ? RATE_W'(1) : i__inj_seed;
  assign prio_seed_s = (i__prio_seed == '0) ? PRIO_W'(1) : i__prio_seed;

  // Accept bookkeeping: the counter and pointer values as they will be after this cycle.
  always_comb begin
    accept_s        = (state_r == ST_PENDING) && i__pifo_ready;
    sent_next_s     = sent_r;
    next_ptr_next_s = next_ptr_r;
    if (accept_s) begin
      sent_next_s     = (sent_r == {CNT_W{1'b1}}) ? sent_r : sent_r + CNT_W'(1);
      next_ptr_next_s = next_ptr_r + PTR_W'(1);
    end else begin
      sent_next_s     = sent_r;
      next_ptr_next_s = next_ptr_r;
    end
    // Once the post-accept count reaches the limit, no further packet may be generated.
    limit_hit_s = (i__num_pkts != '0) && (sent_next_s >= i__num_pkts);
    cand_s      = i__inject_phase && (inj_lfsr_r < i__inj_rate) &&
                  (state_r != ST_DONE) && !limit_hit_s;
  end

  // Next-state logic; the pending packet is only replaced on an accept cycle.
  always_comb begin
    state_next_s = state_r;
    latch_s      = 1'b0;
    inj_adv_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        inj_adv_s = i__inject_phase;
        if (cand_s) begin
          latch_s      = 1'b1;
          state_next_s = ST_PENDING;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PENDING: begin
        inj_adv_s = accept_s && i__inject_phase;
        if (!accept_s) begin
          state_next_s = ST_PENDING;
        end else if (limit_hit_s) begin
          state_next_s = ST_DONE;
        end else if (cand_s) begin
          latch_s      = 1'b1;
          state_next_s = ST_PENDING;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_next_s = ST_DONE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, packet, counter and LFSR registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      pointer_r   <= '0;
      priority_r  <= '0;
      next_ptr_r  <= '0;
      sent_r      <= '0;
      inj_lfsr_r  <= inj_seed_s;
      prio_lfsr_r <= prio_seed_s;
    end else begin
      state_r    <= state_next_s;
      sent_r     <= sent_next_s;
      next_ptr_r <= next_ptr_next_s;
      if (latch_s) begin
        pointer_r   <= next_ptr_next_s;
        priority_r  <= prio_lfsr_r & i__prio_mask;
        prio_lfsr_r <= prio_step(prio_lfsr_r);
      end
      if (inj_adv_s) begin
        inj_lfsr_r <= inj_step(inj_lfsr_r);
      end
    end
  end

  // The strobe follows ready directly; it is masked during reset so a
  // discarded pending packet cannot leak out in the reset cycle.
  assign o__enqueue         = accept_s && !reset;
  assign o__packet_pointer  = pointer_r;
  assign o__packet_priority = priority_r;
  assign o__num_pkts_sent   = sent_r;
  assign o__done            = (state_r == ST_DONE);

endmodule
